// File: rtl/intwb_pipe_array.sv
// Multi-lane integer writeback stage: registers per-lane results and selects the oldest
// same-cycle mispredict redirect as a single-cycle flush, killing younger lanes.
module intwb_pipe_array #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned ROBID_W   = 7,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned RESULT_W  = 64,
  parameter int unsigned PC_W      = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_LANES-1:0]          in_valid,
  input  logic [NUM_LANES*ROBID_W-1:0]  in_robid,
  input  logic [NUM_LANES*PREG_W-1:0]   in_prd,
  input  logic [NUM_LANES-1:0]          in_need_to_wb,
  input  logic [NUM_LANES*RESULT_W-1:0] in_result,
  input  logic [NUM_LANES*PC_W-1:0]     in_pc,
  input  logic [NUM_LANES-1:0]          in_redirect_valid,
  input  logic [NUM_LANES*PC_W-1:0]     in_redirect_target,
  output logic [NUM_LANES-1:0]          wb_valid,
  output logic [NUM_LANES*ROBID_W-1:0]  wb_robid,
  output logic [NUM_LANES*PREG_W-1:0]   wb_prd,
  output logic [NUM_LANES-1:0]          wb_need_to_wb,
  output logic [NUM_LANES*RESULT_W-1:0] wb_result,
  output logic [NUM_LANES*PC_W-1:0]     wb_pc,
  output logic                          flush_valid,
  output logic [ROBID_W-1:0]            flush_robid,
  output logic [PC_W-1:0]               flush_target,
  output logic [31:0]                   redirect_cnt,
  output logic [31:0]                   kill_cnt
);

  // MSB is the wrap bit: differing wrap bits invert the ordering of the low bits.
  function automatic logic is_older(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1]) return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    else                              return a[ROBID_W-2:0] > b[ROBID_W-2:0];
  endfunction

  logic [NUM_LANES-1:0]          wb_valid_q, wb_valid_d;
  logic [NUM_LANES*ROBID_W-1:0]  wb_robid_q, wb_robid_d;
  logic [NUM_LANES*PREG_W-1:0]   wb_prd_q, wb_prd_d;
  logic [NUM_LANES-1:0]          wb_need_q, wb_need_d;
  logic [NUM_LANES*RESULT_W-1:0] wb_result_q, wb_result_d;
  logic [NUM_LANES*PC_W-1:0]     wb_pc_q, wb_pc_d;
  logic                          flush_valid_q, flush_valid_d;
  logic [ROBID_W-1:0]            flush_robid_q, flush_robid_d;
  logic [PC_W-1:0]               flush_target_q, flush_target_d;
  logic [31:0]                   redirect_cnt_q, redirect_cnt_d;
  logic [31:0]                   kill_cnt_q, kill_cnt_d;

  logic [NUM_LANES-1:0] stale_kill, cand, kill, live;
  logic                 r_found;
  logic [ROBID_W-1:0]   r_robid;
  logic [PC_W-1:0]      r_target;
  logic [31:0]          kill_num;
  logic [32:0]          kill_sum;

  always_comb begin
    stale_kill = '0;
    cand       = '0;
    kill       = '0;
    live       = '0;
    r_found    = 1'b0;
    r_robid    = '0;
    r_target   = '0;
    kill_num   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      stale_kill[i] = flush_valid_q && is_older(flush_robid_q, in_robid[i*ROBID_W +: ROBID_W]);
      cand[i]       = in_valid[i] && in_redirect_valid[i] && !stale_kill[i];
    end
    // Strictly-older replacement keeps the lowest lane on an (illegal) id tie.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cand[i] && (!r_found || is_older(in_robid[i*ROBID_W +: ROBID_W], r_robid))) begin
        r_found  = 1'b1;
        r_robid  = in_robid[i*ROBID_W +: ROBID_W];
        r_target = in_redirect_target[i*PC_W +: PC_W];
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      kill[i] = in_valid[i] && (stale_kill[i] ||
                (r_found && is_older(r_robid, in_robid[i*ROBID_W +: ROBID_W])));
      live[i] = in_valid[i] && !kill[i];
      kill_num = kill_num + 32'(kill[i]);
    end
  end

  always_comb begin
    wb_valid_d  = live;
    wb_robid_d  = wb_robid_q;
    wb_prd_d    = wb_prd_q;
    wb_need_d   = wb_need_q;
    wb_result_d = wb_result_q;
    wb_pc_d     = wb_pc_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (live[i]) begin
        wb_robid_d[i*ROBID_W +: ROBID_W]    = in_robid[i*ROBID_W +: ROBID_W];
        wb_prd_d[i*PREG_W +: PREG_W]        = in_prd[i*PREG_W +: PREG_W];
        wb_need_d[i]                        = in_need_to_wb[i];
        wb_result_d[i*RESULT_W +: RESULT_W] = in_result[i*RESULT_W +: RESULT_W];
        wb_pc_d[i*PC_W +: PC_W]             = in_pc[i*PC_W +: PC_W];
      end
    end
    flush_valid_d  = r_found;
    flush_robid_d  = r_found ? r_robid : flush_robid_q;
    flush_target_d = r_found ? r_target : flush_target_q;
    redirect_cnt_d = (r_found && redirect_cnt_q != 32'hFFFF_FFFF) ? redirect_cnt_q + 32'd1
                                                                  : redirect_cnt_q;
    kill_sum       = {1'b0, kill_cnt_q} + {1'b0, kill_num};
    kill_cnt_d     = kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q     <= '0;
      wb_robid_q     <= '0;
      wb_prd_q       <= '0;
      wb_need_q      <= '0;
      wb_result_q    <= '0;
      wb_pc_q        <= '0;
      flush_valid_q  <= 1'b0;
      flush_robid_q  <= '0;
      flush_target_q <= '0;
      redirect_cnt_q <= '0;
      kill_cnt_q     <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_robid_q     <= wb_robid_d;
      wb_prd_q       <= wb_prd_d;
      wb_need_q      <= wb_need_d;
      wb_result_q    <= wb_result_d;
      wb_pc_q        <= wb_pc_d;
      flush_valid_q  <= flush_valid_d;
      flush_robid_q  <= flush_robid_d;
      flush_target_q <= flush_target_d;
      redirect_cnt_q <= redirect_cnt_d;
      kill_cnt_q     <= kill_cnt_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_robid      = wb_robid_q;
  assign wb_prd        = wb_prd_q;
  assign wb_need_to_wb = wb_need_q;
  assign wb_result     = wb_result_q;
  assign wb_pc         = wb_pc_q;
  assign flush_valid   = flush_valid_q;
  assign flush_robid   = flush_robid_q;
  assign flush_target  = flush_target_q;
  assign redirect_cnt  = redirect_cnt_q;
  assign kill_cnt      = kill_cnt_q;

endmodule

// File: doc/intwb_pipe_array.md
INTWB_PIPE_ARRAY -- requirements
Module: intwb_pipe_array

Interface
REQ-001 Parameter NUM_LANES, default 2, number of independent writeback lanes (1..4).
REQ-002 Parameter ROBID_W, default 7, ROB id width including wrap bit (MSB).
REQ-003 Parameter PREG_W, default 6; RESULT_W, default 64; PC_W, default 64, physical-register, result and pc/target widths.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  NUM_LANES  per-lane instruction valid from execute.
REQ-007 in_robid  in  NUM_LANES*ROBID_W  per-lane ROB id; in_prd  in  NUM_LANES*PREG_W; in_need_to_wb  in  NUM_LANES.
REQ-008 in_result  in  NUM_LANES*RESULT_W; in_pc  in  NUM_LANES*PC_W.
REQ-009 in_redirect_valid  in  NUM_LANES; in_redirect_target  in  NUM_LANES*PC_W  per-lane mispredict redirect.
REQ-010 wb_valid  out  NUM_LANES; wb_robid, wb_prd, wb_need_to_wb, wb_result, wb_pc  out  per-lane widths as inputs  registered writeback.
REQ-011 flush_valid  out  1; flush_robid  out  ROBID_W; flush_target  out  PC_W  registered oldest redirect.
REQ-012 redirect_cnt  out  32; kill_cnt  out  32  saturating statistics counters.

Function
REQ-013 Age: a older than b iff (a.MSB==b.MSB) ? a.low<b.low : a.low>b.low; equal ids SHALL not occur across live lanes.
REQ-014 Lane i is live when in_valid[i]=1 and not killed.
REQ-015 Lane i killed by stale flush when flush_valid=1 and in_robid[i] is younger than flush_robid.
REQ-016 Same-cycle oldest redirect R = oldest lane with in_valid & in_redirect_valid not killed per REQ-015; lane i also killed when R exists and in_robid[i] younger than R's robid.
REQ-017 Lane R itself is never killed by REQ-016; its writeback proceeds normally.
REQ-018 Next edge: wb_valid[i] <= live[i]; data fields captured from lane i whenever live[i]=1, held otherwise.
REQ-019 Next edge: flush_valid <= (R exists); flush_robid/flush_target <= R's robid/target when R exists, held otherwise.
REQ-020 flush_valid SHALL be a single-cycle pulse per accepted redirect; two consecutive cycles only with two distinct accepted redirects.
REQ-021 Redirect older than current flush_robid while flush_valid=1 SHALL be accepted and become the next flush; younger one SHALL be discarded.
REQ-022 Latency input to wb_*/flush_* exactly 1 cycle; no backpressure, no ready.
REQ-023 Tie between lanes impossible (REQ-013); if ids equal, lowest lane index wins.
REQ-024 redirect_cnt +1 per cycle R exists; kill_cnt += number of in_valid lanes killed that cycle; both saturate at 32'hFFFF_FFFF.
REQ-025 Age compare SHALL be correct across wrap-bit boundary (e.g. 7'h40 younger than 7'h3F).

Reset
REQ-026 reset_n=0 SHALL immediately clear wb_valid, flush_valid, redirect_cnt, kill_cnt; flush_robid, flush_target, wb data fields to 0.
REQ-027 Reset mid-operation discards all in-flight lanes and any pending flush; first post-reset edge obeys REQ-018/019 with flush_valid treated as 0.

Verification
REQ-028 Lane0 robid 5 valid, lane1 robid 6 valid, no redirect -> next cycle wb_valid=2'b11, flush_valid=0, kill_cnt=0.
REQ-029 Lane0 robid 9 redirect target 0x8000_1000, lane1 robid 10 valid -> wb_valid=2'b01, flush_valid=1, flush_robid=9, flush_target=0x8000_1000, kill_cnt=1, redirect_cnt=1.
REQ-030 Lane0 robid 0x3F redirect, lane1 robid 0x40 redirect (same cycle) -> flush_robid=0x3F, wb_valid=2'b01.
REQ-031 Cycle N flush from robid 20; cycle N+1 lane0 robid 21, lane1 robid 18 redirect -> lane0 killed, lane1 written back, flush_robid=18, flush_valid high second cycle.
REQ-032 Preload redirect_cnt near saturation via 2^32 redirects (or force) -> holds at 0xFFFF_FFFF; assert reset_n=0 mid-cycle with flush pending -> flush_valid, wb_valid, counters 0 immediately.
